// File: rtl/scroll_sequencer.sv
// Frame-rate controller for the road/river background renderers: turns accel/brake
// and crash events into a speed level and per-frame bursts of scroll-step pulses.
module scroll_sequencer #(
  parameter int SPEED_W        = 3,
  parameter int MAX_SPEED      = 7,
  parameter int CRASH_FRAMES   = 120,
  parameter int RESPAWN_FRAMES = 60,
  parameter int DIST_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               accel,
  input  logic               brake,
  input  logic               crash,
  output logic               update_signal,
  output logic               alive,
  output logic [SPEED_W-1:0] speed,
  output logic [DIST_W-1:0]  distance,
  output logic [1:0]         state
);

  // update_signal is a one-cycle strobe with no back-pressure: the renderer must
  // consume every pulse it sees, one scroll step per high cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CRASH   = 2'd2,
    RESPAWN = 2'd3
  } state_t;

  localparam int FRAMES_MAX = (CRASH_FRAMES > RESPAWN_FRAMES) ? CRASH_FRAMES : RESPAWN_FRAMES;
  localparam int FC_W       = $clog2(FRAMES_MAX + 1);

  localparam logic [SPEED_W-1:0] SPEED_TOP    = SPEED_W'(MAX_SPEED);
  localparam logic [FC_W-1:0]    CRASH_LAST   = FC_W'(CRASH_FRAMES - 1);
  localparam logic [FC_W-1:0]    RESPAWN_LAST = FC_W'(RESPAWN_FRAMES - 1);

  state_t             state_q, state_n;
  logic [SPEED_W-1:0] speed_q, speed_n;
  logic [SPEED_W-1:0] burst_q, burst_n;
  logic [SPEED_W-1:0] speed_dec, speed_inc;
  logic [FC_W-1:0]    frame_q, frame_n;
  logic [DIST_W-1:0]  dist_q, dist_n;
  logic               upd_q, upd_n;
  logic               alive_q, alive_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      speed_q <= '0;
      burst_q <= '0;
      frame_q <= '0;
      dist_q  <= '0;
      upd_q   <= 1'b0;
      alive_q <= 1'b1;
    end else begin
      state_q <= state_n;
      speed_q <= speed_n;
      burst_q <= burst_n;
      frame_q <= frame_n;
      dist_q  <= dist_n;
      upd_q   <= upd_n;
      alive_q <= alive_n;
    end
  end

  always_comb begin
    speed_dec = (speed_q < SPEED_W'(2)) ? '0 : speed_q - SPEED_W'(2);
    speed_inc = (speed_q >= SPEED_TOP) ? SPEED_TOP : speed_q + SPEED_W'(1);
  end

  always_comb begin
    state_n = state_q;
    speed_n = speed_q;
    burst_n = burst_q;
    frame_n = frame_q;
    dist_n  = dist_q;
    alive_n = alive_q;
    upd_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          speed_n = '0;
          dist_n  = '0;
        end
      end
      RUN, RESPAWN: begin
        if (state_q == RUN && crash) begin
          // Crash beats a coincident tick and kills any burst in flight.
          state_n = CRASH;
          speed_n = '0;
          alive_n = 1'b0;
          frame_n = '0;
          burst_n = '0;
        end else if (frame_tick) begin
          if (brake)      speed_n = speed_dec;
          else if (accel) speed_n = speed_inc;
          // First pulse of the burst is issued here; burst_q holds the remainder.
          upd_n   = (speed_q != '0);
          burst_n = (speed_q != '0) ? speed_q - SPEED_W'(1) : '0;
          if (state_q == RESPAWN) begin
            if (frame_q == RESPAWN_LAST) begin
              state_n = RUN;
              frame_n = '0;
            end else begin
              frame_n = frame_q + FC_W'(1);
            end
          end
        end else if (burst_q != '0) begin
          upd_n   = 1'b1;
          burst_n = burst_q - SPEED_W'(1);
        end
      end
      CRASH: begin
        if (frame_tick) begin
          if (frame_q == CRASH_LAST) begin
            state_n = RESPAWN;
            alive_n = 1'b1;
            speed_n = SPEED_W'(1);
            frame_n = '0;
          end else begin
            frame_n = frame_q + FC_W'(1);
          end
        end
      end
    endcase

    if (upd_n && (dist_q != '1)) dist_n = dist_q + DIST_W'(1);
  end

  assign update_signal = upd_q;
  assign alive         = alive_q;
  assign speed         = speed_q;
  assign distance      = dist_q;
  assign state         = state_q;

endmodule
